// File: rtl/enc_sched_pkg.sv
// Shared types and sizes for the encoder poll scheduler.
//   sched_state_e : scheduler FSM states
//   NUM_CH        : encoder/pid channels sharing the i2c master
//   ANGLE_W       : encoder angle width
//   CHAN_W        : channel index width
//   FAIL_W        : per-channel consecutive-failure counter width
package enc_sched_pkg;

    localparam int NUM_CH  = 4;
    localparam int ANGLE_W = 12;
    localparam int CHAN_W  = 2;
    localparam int FAIL_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ARB,
        ST_START,
        ST_XFER,
        ST_DELIVER
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : requesting channels
//   ptr       : first channel to consider (the channel after the last grant)
//   grant     : one-hot grant, zero when req is zero
//   grant_idx : index of the granted channel
module rr_arbiter
    import enc_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CHAN_W-1:0] grant_idx
);

    always_comb begin
        logic              found;
        logic [CHAN_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Index arithmetic wraps 3->0 because CHAN_W bits cover NUM_CH exactly.
            cand = ptr + CHAN_W'(i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/encoder_poll_sched.sv
// Shares one i2c master among the wheel-angle encoders. Polls channels
// round-robin (rotating pids first), latches each returned angle and
// strobes that channel's rd_done; flags encoders that keep failing.
//   clock, reset_n      : clock, async active-low reset
//   enable, chan_enable : run enable, channels included in polling
//   chan_active         : pids mid-rotation, polled with precedence
//   poll_interval       : idle cycles between transactions
//   i2c_start/i2c_chan  : request and channel select to the i2c master
//   i2c_done/err/rd_data: completion, error and read data from the master
//   angle_out, rd_done  : per-channel angle and one-cycle update strobe
//   stale, busy         : failing-encoder flags, transaction in flight
//
// state   | meaning
// IDLE    | disabled or no channel enabled
// WAIT    | counting poll_interval idle cycles
// ARB     | pick next channel, register i2c_chan
// START   | one-cycle i2c_start, arm timeout
// XFER    | waiting for done / err / timeout
// DELIVER | result visible (angle_out, rd_done, stale)
module encoder_poll_sched
    import enc_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAX_FAIL    = 3
)(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         chan_enable,
    input  logic [NUM_CH-1:0]         chan_active,
    input  logic [15:0]               poll_interval,
    output logic                      i2c_start,
    output logic [CHAN_W-1:0]         i2c_chan,
    input  logic                      i2c_done,
    input  logic                      i2c_err,
    input  logic [ANGLE_W-1:0]        i2c_rd_data,
    output logic [NUM_CH*ANGLE_W-1:0] angle_out,
    output logic [NUM_CH-1:0]         rd_done,
    output logic [NUM_CH-1:0]         stale,
    output logic                      busy
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_SAT = FAIL_W'(MAX_FAIL);

    sched_state_e       state_q, state_d;
    logic [15:0]        poll_q, poll_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [CHAN_W-1:0]  ptr_q, ptr_d;       // next channel to consider
    logic [FAIL_W-1:0]  fail_q [NUM_CH];
    logic [FAIL_W-1:0]  fail_d [NUM_CH];
    logic [ANGLE_W-1:0] angle_q [NUM_CH];
    logic [ANGLE_W-1:0] angle_d [NUM_CH];
    logic [NUM_CH-1:0]  rd_done_q, rd_done_d;

    logic [NUM_CH-1:0]  req, grant;
    logic [CHAN_W-1:0]  grant_idx;
    logic               run_ok;

    assign req    = ((chan_enable & chan_active) != '0) ? (chan_enable & chan_active) : chan_enable;
    assign run_ok = enable && (chan_enable != '0);

    rr_arbiter u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        to_d      = to_q;
        chan_d    = chan_q;
        ptr_d     = ptr_q;
        fail_d    = fail_q;
        angle_d   = angle_q;
        rd_done_d = '0;

        case (state_q)
            ST_IDLE, ST_DELIVER: begin
                // A zero interval skips WAIT so the next start lands 3 cycles after done.
                if (!run_ok) begin
                    state_d = ST_IDLE;
                end else if (poll_interval == '0) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_WAIT;
                    poll_d  = poll_interval;
                end
            end
            ST_WAIT: begin
                if (!run_ok) begin
                    state_d = ST_IDLE;
                end else if (poll_q <= 16'd1) begin
                    state_d = ST_ARB;
                end else begin
                    poll_d = poll_q - 16'd1;
                end
            end
            ST_ARB: begin
                if (grant != '0) begin
                    state_d = ST_START;
                    chan_d  = grant_idx;
                    ptr_d   = grant_idx + CHAN_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_XFER;
                to_d    = TO_LOAD;
            end
            ST_XFER: begin
                if (i2c_err || i2c_done || (to_q == '0)) begin
                    state_d = ST_DELIVER;
                    if (i2c_done && !i2c_err) begin
                        angle_d[chan_q]   = i2c_rd_data;
                        rd_done_d[chan_q] = 1'b1;
                        fail_d[chan_q]    = '0;
                    end else if (fail_q[chan_q] != FAIL_SAT) begin
                        fail_d[chan_q] = fail_q[chan_q] + FAIL_W'(1);
                    end
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            poll_q    <= '0;
            to_q      <= '0;
            chan_q    <= '0;
            ptr_q     <= '0;
            rd_done_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                fail_q[i]  <= '0;
                angle_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            to_q      <= to_d;
            chan_q    <= chan_d;
            ptr_q     <= ptr_d;
            rd_done_q <= rd_done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                fail_q[i]  <= fail_d[i];
                angle_q[i] <= angle_d[i];
            end
        end
    end

    assign i2c_start = (state_q == ST_START);
    assign busy      = (state_q == ST_START) || (state_q == ST_XFER) || (state_q == ST_DELIVER);
    assign i2c_chan  = chan_q;
    assign rd_done   = rd_done_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign angle_out[g*ANGLE_W +: ANGLE_W] = angle_q[g];
        assign stale[g] = (fail_q[g] == FAIL_SAT);
    end

endmodule
